// File: rtl/fft_frame_loader_if.sv
// Sample stream, RAM write port and frame handoff signals for the FFT frame loader.
// The loader is the slave side; the source/RAM/pipeline environment is the master.
interface fft_frame_loader_if #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 4
);
  logic [2*DATA_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;
  logic                bitrev_en;
  logic                wr_en;
  logic                wr_bank;
  logic [LOG2N-1:0]    wr_addr;
  logic [2*DATA_W-1:0] wr_data;
  logic                frame_start;
  logic                frame_bank;
  logic                frame_done;

  modport slave (
    input  s_data, s_valid, bitrev_en, frame_done,
    output s_ready, wr_en, wr_bank, wr_addr, wr_data, frame_start, frame_bank
  );

  modport master (
    output s_data, s_valid, bitrev_en, frame_done,
    input  s_ready, wr_en, wr_bank, wr_addr, wr_data, frame_start, frame_bank
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Writes a valid/ready sample stream into a ping-pong sample RAM (natural or
// bit-reversed order) and hands completed banks to the FFT pipeline in fill order.
module fft_frame_loader #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 4
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  fft_frame_loader_if.slave   bus,
  output logic [7:0]          stall_cnt
);

  // state       | meaning
  // PIPE_IDLE   | no frame in flight; issue the next full bank in fill order
  // PIPE_BUSY   | frame_bank owned by the pipeline until frame_done
  typedef enum logic {PIPE_IDLE = 1'b0, PIPE_BUSY = 1'b1} pipe_t;

  pipe_t               pipe_state, pipe_next;
  logic                fill_bank;
  logic                issue_bank;
  logic [LOG2N-1:0]    cnt;
  logic [1:0]          full, full_next;
  logic                brev_mode;
  logic                accept, last_sample, addr_mode;
  logic                issue_now, release_now;
  logic [LOG2N-1:0]    addr;
  logic [2*DATA_W-1:0] sample;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int k = 0; k < LOG2N; k++) r[k] = v[LOG2N-1-k];
    return r;
  endfunction

  assign bus.s_ready  = !full[fill_bank];
  assign accept       = bus.s_valid && !full[fill_bank];
  assign last_sample  = &cnt;
  assign sample       = bus.s_data;
  // the mode for sample 0 comes straight from the pin; later samples use the latch
  assign addr_mode    = (cnt == '0) ? bus.bitrev_en : brev_mode;
  assign addr         = addr_mode ? bit_rev(cnt) : cnt;

  always_comb begin
    pipe_next   = pipe_state;
    issue_now   = 1'b0;
    release_now = 1'b0;
    case (pipe_state)
      PIPE_IDLE: if (full[issue_bank]) begin
        issue_now = 1'b1;
        pipe_next = PIPE_BUSY;
      end
      PIPE_BUSY: if (bus.frame_done) begin
        release_now = 1'b1;
        pipe_next   = PIPE_IDLE;
      end
    endcase
  end

  always_comb begin
    full_next = full;
    if (release_now) full_next[bus.frame_bank] = 1'b0;
    if (accept && last_sample) full_next[fill_bank] = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) pipe_state <= PIPE_IDLE;
    else     pipe_state <= pipe_next;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      fill_bank       <= 1'b0;
      issue_bank      <= 1'b0;
      cnt             <= '0;
      full            <= 2'b00;
      brev_mode       <= 1'b0;
      stall_cnt       <= 8'd0;
      bus.wr_en       <= 1'b0;
      bus.wr_bank     <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.frame_start <= 1'b0;
      bus.frame_bank  <= 1'b0;
    end else begin
      bus.wr_en       <= accept;
      bus.frame_start <= issue_now;
      full            <= full_next;
      if (accept) begin
        bus.wr_bank <= fill_bank;
        bus.wr_addr <= addr;
        bus.wr_data <= sample;
        cnt         <= cnt + 1'b1;
        if (cnt == '0) brev_mode <= bus.bitrev_en;
        if (last_sample) fill_bank <= ~fill_bank;
      end
      if (issue_now) begin
        bus.frame_bank <= issue_bank;
        issue_bank     <= ~issue_bank;
      end
      if (bus.s_valid && full[fill_bank] && stall_cnt != 8'd255)
        stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule
